// File: rtl/cpu_pkg.sv
// Shared LEGv8 CPU definitions: instruction field bounds and the fetch FSM
// state type, imported by the fetch unit and its interface.
package cpu_pkg;

  localparam int INSTR_W    = 32;
  localparam int OPCODE_W   = 11;
  localparam int OPC_HI     = 31;
  localparam int OPC_LO     = 21;
  localparam int CBZ_OFF_HI = 23;
  localparam int CBZ_OFF_LO = 5;
  localparam int CBZ_OFF_W  = CBZ_OFF_HI - CBZ_OFF_LO + 1;
  localparam int PERF_W     = 32;

  typedef enum logic [1:0] {
    F_IDLE,
    F_REQ,
    F_VALID
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus: instruction-memory req/ack port plus the valid/ready decode
// port. The master modport is the fetch unit, the slave modport its environment.
interface instr_fetch_unit_if
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 64
);

  logic                imem_req;
  logic [ADDR_W-1:0]   imem_addr;
  logic                imem_ack;
  logic [INSTR_W-1:0]  imem_rdata;

  logic                ins_valid;
  logic [INSTR_W-1:0]  ins_out;
  logic [OPCODE_W-1:0] opcode;
  logic [ADDR_W-1:0]   pc_out;
  logic                dec_ready;
  logic                branch;
  logic                zero;

  logic [PERF_W-1:0]   perf_fetched;
  logic [PERF_W-1:0]   perf_taken;

  modport master (
    output imem_req, imem_addr, ins_valid, ins_out, opcode, pc_out,
           perf_fetched, perf_taken,
    input  imem_ack, imem_rdata, dec_ready, branch, zero
  );

  modport slave (
    input  imem_req, imem_addr, ins_valid, ins_out, opcode, pc_out,
           perf_fetched, perf_taken,
    output imem_ack, imem_rdata, dec_ready, branch, zero
  );

endinterface

// File: rtl/instr_fetch_unit_next_pc.sv
// Combinational next-PC: PC+4, or the CBZ target PC + (sext(offset19) << 2),
// both wrapping modulo 2^ADDR_W.
module fetch_next_pc
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 64
) (
  input  logic [ADDR_W-1:0]    pc_i,
  input  logic [CBZ_OFF_W-1:0] off_i,
  input  logic                 take_i,
  output logic [ADDR_W-1:0]    next_pc_o
);

  logic [ADDR_W-1:0] br_off;

  // Word offset becomes a byte offset, so the target stays 4-byte aligned.
  assign br_off    = {{(ADDR_W-CBZ_OFF_W-2){off_i[CBZ_OFF_W-1]}}, off_i, 2'b00};
  assign next_pc_o = take_i ? pc_i + br_off : pc_i + ADDR_W'(4);

endmodule

// File: rtl/instr_fetch_unit.sv
// LEGv8 fetch stage: holds the PC, fetches over req/ack, presents the IR to
// decode over valid/ready. Optional perf counters under FETCH_PERF_EN.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  instr_fetch_unit_if.master  bus
);

  fetch_state_t       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d, next_pc;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic               hs;

  assign hs = (state_q == F_VALID) && bus.dec_ready;

  fetch_next_pc #(.ADDR_W(ADDR_W)) u_next_pc (
    .pc_i      (pc_q),
    .off_i     (ir_q[CBZ_OFF_HI:CBZ_OFF_LO]),
    .take_i    (bus.branch && bus.zero),
    .next_pc_o (next_pc)
  );

  // NOTE: flops use non-blocking assignments so every register samples the
  // pre-edge values of its neighbours, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= F_IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  // NOTE: every combinational output gets a default first, so no path through
  // the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    unique case (state_q)
      F_IDLE:  state_d = F_REQ;
      F_REQ: begin
        if (bus.imem_ack) begin
          ir_d    = bus.imem_rdata;
          state_d = F_VALID;
        end
      end
      F_VALID: begin
        if (hs) begin
          pc_d    = next_pc;
          state_d = F_REQ;
        end
      end
      default: state_d = F_IDLE;
    endcase
  end

  // Decoded from state alone, so an async reset drops imem_req at once.
  always_comb begin
    bus.imem_req  = (state_q == F_REQ);
    bus.ins_valid = (state_q == F_VALID);
  end

  assign bus.imem_addr = pc_q;
  assign bus.pc_out    = pc_q;
  assign bus.ins_out   = ir_q;
  assign bus.opcode    = ir_q[OPC_HI:OPC_LO];

`ifdef FETCH_PERF_EN
  logic              take;
  logic [PERF_W-1:0] perf_fetched_q, perf_taken_q;

  assign take = hs && bus.branch && bus.zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched_q <= '0;
      perf_taken_q   <= '0;
    end else begin
      if (hs)   perf_fetched_q <= perf_fetched_q + PERF_W'(1);
      if (take) perf_taken_q   <= perf_taken_q + PERF_W'(1);
    end
  end

  assign bus.perf_fetched = perf_fetched_q;
  assign bus.perf_taken   = perf_taken_q;
`else
  assign bus.perf_fetched = '0;
  assign bus.perf_taken   = '0;
`endif

endmodule
